// File: rtl/multicycle_data_mem.sv
// Purpose     : 16-bit word data memory for a multicycle CPU; one request in flight at a time.
// Latency     : data_valid pulses for the single cycle after accept edge + LATENCY.
// Backpressure: busy is high from accept through DONE; enable is ignored while busy.
//
// Ports:
//   clk, rst          - sole clock; synchronous active-high reset
//   enable, wr        - request strobe and store(1)/load(0) select, sampled in IDLE
//   addr, data_in     - byte address (word = addr[ADDR_WIDTH:1]) and store data
//   busy, data_valid  - request in flight / one-cycle completion pulse
//   data_out, err     - registered load result; misalignment flag qualified by data_valid
// Build option: define MEM_ALIGN_CHECK_EN to reject odd byte addresses with err.
module multicycle_data_mem #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic        busy,
    output logic        data_valid,
    output logic [15:0] data_out,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              count;
    logic                    req_wr;
    logic [ADDR_WIDTH-1:0]   req_idx;
    logic [15:0]             req_dat;
    logic                    accept;
    logic                    access;
    logic                    addr_bad;

    logic [15:0] mem [0:(1<<ADDR_WIDTH)-1];

    assign accept = (state == IDLE) && enable;
    // The access edge is the last BUSY edge, when the down-counter has drained.
    assign access = (state == BUSY) && (count == 4'd0);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = (state != IDLE);
        data_valid = (state == DONE);
        case (state)
            IDLE:    if (enable) state_nxt = BUSY;
            BUSY:    if (count == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- request latch, counter, load result ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= 4'd0;
            req_wr   <= 1'b0;
            req_idx  <= '0;
            req_dat  <= 16'h0000;
            data_out <= 16'h0000;
        end else begin
            if (accept) begin
                req_wr  <= wr;
                req_idx <= addr[ADDR_WIDTH:1];
                req_dat <= data_in;
                count   <= 4'(LATENCY - 1);
            end else if ((state == BUSY) && (count != 4'd0)) begin
                count <= count - 4'd1;
            end
            if (access && !req_wr && !addr_bad) begin
                data_out <= mem[req_idx];
            end
        end
    end

    // Storage is deliberately left out of reset; a reset on the access edge
    // still suppresses the write so an abandoned store never lands.
    always_ff @(posedge clk) begin
        if (!rst && access && req_wr && !addr_bad) begin
            mem[req_idx] <= req_dat;
        end
    end

    // Address bits above the word index alias away by design.
    generate
        if (ADDR_WIDTH < 15) begin : g_hi_addr
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr[15:ADDR_WIDTH+1];
        end
    endgenerate

`ifdef MEM_ALIGN_CHECK_EN
    logic req_misalign;
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_misalign <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (accept) begin
                req_misalign <= addr[0];
            end
            if (access) begin
                err_q <= req_misalign;
            end
        end
    end

    assign addr_bad = req_misalign;
    assign err      = data_valid & err_q;
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = addr[0];
    assign addr_bad        = 1'b0;
    assign err             = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_data_mem.sv
// Purpose     : self-checking bench for multicycle_data_mem against a word-array reference model.
// Latency     : expects data_valid LATENCY cycles after each accept edge, busy for LATENCY+1 cycles.
// Backpressure: issues a new request only after busy has dropped.
module tb_multicycle_data_mem;

    localparam int AW  = 10;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        busy;
    logic        data_valid;
    logic [15:0] data_out;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: word-indexed memory, only written entries are known.
    logic [15:0] ref_mem [int];
    logic [15:0] ref_dout;
    bit          dout_known;

    multicycle_data_mem #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .busy       (busy),
        .data_valid (data_valid),
        .data_out   (data_out),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int widx(input logic [15:0] a);
        return (int'(a) / 2) % (1 << AW);
    endfunction

    function automatic bit misaligned(input logic [15:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        return (a % 2) == 1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request from a negedge with the DUT idle; optionally keep a
    // conflicting store strobe asserted for the whole time the DUT is busy.
    task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input bit hold, input logic [15:0] ha);
        int cyc;
        int busy_cnt;
        bit exp_err;
        enable  = 1'b1;
        wr      = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
        if (hold) begin
            wr      = 1'b1;
            addr    = ha;
            data_in = ~d;
        end else begin
            enable = 1'b0;
        end
        @(negedge clk);
        cyc      = 0;
        busy_cnt = 0;
        while (data_valid !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        if (busy === 1'b1) busy_cnt++;
        enable = 1'b0;

        exp_err = misaligned(a);
        if (!exp_err) begin
            if (w) begin
                ref_mem[widx(a)] = d;
            end else if (ref_mem.exists(widx(a))) begin
                ref_dout   = ref_mem[widx(a)];
                dout_known = 1'b1;
            end else begin
                dout_known = 1'b0;
            end
        end

        chk("latency", 16'(cyc), 16'(LAT));
        chk("busy_cycles", 16'(busy_cnt), 16'(LAT + 1));
        chk("err", {15'd0, err}, {15'd0, exp_err});
        if (dout_known) chk("data_out", data_out, ref_dout);

        @(negedge clk);
        chk("idle_busy", {15'd0, busy}, 16'd0);
        chk("valid_one_cycle", {15'd0, data_valid}, 16'd0);
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d);
        do_req(1'b1, a, d, 1'b0, 16'h0000);
    endtask

    task automatic load(input logic [15:0] a);
        do_req(1'b0, a, 16'h0000, 1'b0, 16'h0000);
    endtask

    initial begin
        logic [15:0] ra;
        rst        = 1'b1;
        enable     = 1'b0;
        wr         = 1'b0;
        addr       = 16'h0000;
        data_in    = 16'h0000;
        ref_dout   = 16'h0000;
        dout_known = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_valid", {15'd0, data_valid}, 16'd0);
        chk("rst_data_out", data_out, 16'h0000);
        chk("rst_err", {15'd0, err}, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        // Store then load.
        store(16'h0010, 16'hBEEF);
        load(16'h0010);
        chk("beef_direct", data_out, 16'hBEEF);

        // Wrap-around aliasing.
        store(16'h0000, 16'h1234);
        load(16'h0800);
        chk("wrap_alias", data_out, 16'h1234);

        // Highest word index, reached through an aliased address.
        store(16'h07FE, 16'hCAFE);
        load(16'hFFFE);
        chk("top_word", data_out, 16'hCAFE);

        // Mid-flight strobe with a different address must be ignored.
        store(16'h0040, 16'h0F0F);
        do_req(1'b1, 16'h0042, 16'h3C3C, 1'b1, 16'h0040);
        load(16'h0040);
        chk("hold_other_kept", data_out, 16'h0F0F);
        load(16'h0042);
        chk("hold_first_done", data_out, 16'h3C3C);

        // Reset in the middle of a store abandons it.
        store(16'h0004, 16'h5555);
        enable  = 1'b1;
        wr      = 1'b1;
        addr    = 16'h0004;
        data_in = 16'hAAAA;
        @(posedge clk);
        #1 enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {15'd0, busy}, 16'd0);
        chk("midrst_data_out", data_out, 16'h0000);
        chk("midrst_valid", {15'd0, data_valid}, 16'd0);
        ref_dout   = 16'h0000;
        dout_known = 1'b1;
        repeat (LAT + 2) begin
            @(negedge clk);
            chk("midrst_stays_idle", {15'd0, busy}, 16'd0);
        end
        load(16'h0004);
        chk("midrst_not_written", data_out, 16'h5555);

        // Reset wins over a simultaneous request.
        store(16'h0020, 16'h1111);
        rst     = 1'b1;
        enable  = 1'b1;
        wr      = 1'b1;
        addr    = 16'h0020;
        data_in = 16'h7777;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        chk("rst_prio_busy", {15'd0, busy}, 16'd0);
        ref_dout = 16'h0000;
        chk("rst_prio_data_out", data_out, 16'h0000);
        load(16'h0020);
        chk("rst_prio_not_written", data_out, 16'h1111);

        // Misaligned store onto the word at 0x0002.
        store(16'h0002, 16'h1357);
        store(16'h0003, 16'h2468);
        load(16'h0002);
`ifdef MEM_ALIGN_CHECK_EN
        chk("misalign_word", data_out, 16'h1357);
`else
        chk("misalign_word", data_out, 16'h2468);
`endif

        // Randomized traffic over a small word pool with aliased upper bits.
        for (int i = 0; i < 32; i++) begin
            ra = 16'((i * 2) | ($urandom_range(0, 31) << 11));
            store(ra, 16'($urandom));
        end
        for (int i = 0; i < 60; i++) begin
            ra = 16'(($urandom_range(0, 31) * 2) | ($urandom_range(0, 31) << 11));
            if ($urandom_range(0, 7) == 0) ra = ra | 16'h0001;
            if ($urandom_range(0, 1) == 1) store(ra, 16'($urandom));
            else load(ra);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
